ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit: the requesting side of the instruction ROM port. Holds the program counter and drives a byte address to the ROM. Captures the 16-bit instruction the ROM returns combinationally in the same cycle. Feeds decode through a 2-entry buffer with a valid/ready handshake and supports PC redirect for branches and jumps.

## Interface
- PC_W, 30, PC and ROM address width (byte address, halfword-aligned)
- RESET_PC, 0, PC value loaded on reset
- sys_clk  in  1  clock; all state updates on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  permits new fetches; 0 freezes the PC and stops pushes, but pops still occur
- rom_pc  out  PC_W  byte address to ROM, always equal to pc_q
- rom_instruction  in  16  ROM data for rom_pc, valid in the same cycle
- redirect_valid  in  1  one-cycle request to restart fetch
- redirect_pc  in  PC_W  new fetch address; bit 0 is ignored (forced 0)
- if_valid  out  1  buffer head is valid
- if_instr  out  16  instruction at buffer head
- if_pc  out  PC_W  address of if_instr
- if_ready  in  1  decode accepts the head this cycle

## Operation
- **State:**
  - pc_q[PC_W-1:0]
  - 2-entry buffer of {pc, instr}
  - count[1:0] (0..2)
  - FSM state IDLE/RUN/FULL
- **pop** = if_valid & if_ready.
- **push** = fetch_en & ~redirect_valid & (count<2 | pop). On push, store {pc_q, rom_instruction}; pc_q <= pc_q + 2, wrapping modulo 2^PC_W (max halfword address + 2 -> 0).
- **Redirect has priority over everything:**
  - count <= 0 and pointers cleared.
  - pc_q <= {redirect_pc[PC_W-1:1], 1'b0}.
  - No push that cycle.
  - A pop in the redirect cycle still counts as a completed transfer.
- **Simultaneous push and pop:** count unchanged; order is preserved.
- **Outputs:** if_valid = (count != 0). if_instr and if_pc come from the head entry. When count=0 they hold the last head value; their content is don't-care.
- **FSM** (state is registered, transitions are evaluated every cycle):
  - IDLE: fetch_en=0. Goes to RUN when fetch_en=1.
  - RUN: fetch_en=1 and next count<2. Goes to FULL when next count=2, and to IDLE when fetch_en=0.
  - FULL: next count=2. Goes to RUN when a pop with no push lowers count. Redirect forces RUN (if fetch_en=1) or IDLE.
- pc_q never changes without a push or a redirect.

## Timing
- **Reset (asynchronous, sys_rst_n=0):**
  - pc_q=RESET_PC, rom_pc=RESET_PC
  - count=0, if_valid=0
  - if_instr=16'h0000, if_pc=0
  - state=IDLE
- **First fetch:** with fetch_en=1 held, the first rising edge after reset release pushes RESET_PC, and if_valid=1 follows that edge.
- **Fetch-to-output latency:** 1 cycle. An instruction fetched at edge N is visible at if_* after edge N.
- **Throughput:** 1 instruction/cycle while if_ready=1.
- **Redirect:** asserted in cycle N (sampled at edge N).
  - After edge N: if_valid=0 and rom_pc=redirect target.
  - After edge N+1: if_valid=1 with if_pc equal to the target.
- **Back-pressure:** with if_ready=0, count reaches 2 after two pushes and pc_q then holds. When if_ready rises, push resumes in the same cycle (count<2|pop), so there is no bubble.
- **Reset mid-operation:** immediate return to the reset values; buffer contents are discarded.

## Structure
- Shared header cpu_defs.vh holds PC_W, RESET_PC, the instruction width (16), and the FSM encodings (IDLE=2'd0, RUN=2'd1, FULL=2'd2).
- Sub-module ifetch_buf: a 2-entry synchronous FIFO (push, pop, flush, count, head data), reset by sys_rst_n.
- The top level contains the PC register, push/pop/redirect logic and the FSM.

## Test plan
- **Reset then stream:** ROM model returns instr = pc[15:0] ^ 16'hA5A5, fetch_en=1, if_ready=1.
  - Expect if_pc = 0,2,4,6 on consecutive cycles.
  - Expect if_instr = 16'hA5A5, 16'hA5A7, 16'hA5A1, 16'hA5A3.
  - if_valid must be low until the first edge after reset release.
- **Back-pressure:** hold if_ready=0 for 5 cycles.
  - count saturates at 2, rom_pc holds at 4, and if_pc stays 0 throughout.
  - After releasing if_ready, expect if_pc = 0,2,4 with no gaps and none skipped.
- **Redirect:** pulse redirect_valid with redirect_pc=30'h101 while the buffer is full.
  - Next cycle: if_valid=0, rom_pc=30'h100.
  - Cycle after: if_pc=30'h100, then 30'h102.
- **Redirect with pop:** redirect and if_ready=1 in the same cycle.
  - The head entry counts as accepted.
  - The second buffered entry is never presented.
- **Wrap-around:** redirect to 30'h3FFFFFFE.
  - Expect if_pc = 30'h3FFFFFFE, then 30'h0000000.
- **Async reset mid-stream:** drop sys_rst_n between clock edges.
  - if_valid=0 and rom_pc=0 immediately, without waiting for an edge.
  - After release, fetch restarts at 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction fetch slice.
//   DEF_PC_W     - default PC / ROM byte-address width
//   DEF_RESET_PC - default PC value loaded on reset
//   INSTR_W      - instruction width
//   fetch_state_e - fetch FSM states
package ifetch_pkg;

  localparam int unsigned DEF_PC_W     = 30;
  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned INSTR_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: 2-entry synchronous FIFO of {pc, instr} between fetch and decode.
//   sys_clk, sys_rst_n  - clock, asynchronous active-low reset
//   push_i              - write {wr_pc_i, wr_instr_i} (caller guarantees space or pop)
//   pop_i               - drop the head entry (ignored when empty)
//   flush_i             - discard all entries; overrides push and pop
//   count_o             - number of valid entries (0..2)
//   head_pc_o/head_instr_o - head entry contents (stale when count_o == 0)
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int unsigned PC_W = DEF_PC_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    wr_pc_i,
  input  logic [INSTR_W-1:0] wr_instr_i,
  output logic [1:0]         count_o,
  output logic [PC_W-1:0]    head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o
);

  logic [PC_W-1:0]    pc_mem_q    [2];
  logic [INSTR_W-1:0] instr_mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;
  logic               do_pop;
  logic               do_push;

  assign do_pop  = pop_i & (count_q != 2'd0) & ~flush_i;
  assign do_push = push_i & ~flush_i;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // With count==2 and a pop, wr_ptr aliases the slot being read; the
      // head is read combinationally before the edge, so the overwrite is safe.
      if (do_push) begin
        pc_mem_q[wr_ptr_q]    <= wr_pc_i;
        instr_mem_q[wr_ptr_q] <= wr_instr_i;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o      = count_q;
  assign head_pc_o    = pc_mem_q[rd_ptr_q];
  assign head_instr_o = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit driving the instruction ROM port.
//   sys_clk, sys_rst_n  - clock, asynchronous active-low reset
//   fetch_en            - permit new fetches (pops continue when low)
//   rom_pc / rom_instruction - ROM byte address out, same-cycle instruction in
//   redirect_valid / redirect_pc - restart fetch at redirect_pc (bit 0 forced 0)
//   if_valid / if_instr / if_pc / if_ready - valid/ready handshake to decode
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               fetch_en,
  output logic [PC_W-1:0]    rom_pc,
  input  logic [INSTR_W-1:0] rom_instruction,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               if_ready
);

  logic [PC_W-1:0] pc_q;
  fetch_state_e    state_q;
  logic [1:0]      count;
  logic [1:0]      cnt_d;
  logic            pop;
  logic            push;
  logic            has_space;

  assign pop = if_valid & if_ready;

  // ST_FULL is registered from the next count, so it is exactly count==2;
  // the state replaces a separate count<2 compare.
  assign has_space = (state_q != ST_FULL);
  assign push      = fetch_en & ~redirect_valid & (has_space | pop);

  always_comb begin
    cnt_d = count;
    if (redirect_valid) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_d = count + 2'd1;
        2'b01:   cnt_d = count - 2'd1;
        default: cnt_d = count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[PC_W-1:1], 1'b0};
    end else if (push) begin
      pc_q <= pc_q + PC_W'(2);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else if (cnt_d == 2'd2) begin
      state_q <= ST_FULL;
    end else if (fetch_en) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= ST_IDLE;
    end
  end

  ifetch_buf #(
    .PC_W (PC_W)
  ) u_buf (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .wr_pc_i      (pc_q),
    .wr_instr_i   (rom_instruction),
    .count_o      (count),
    .head_pc_o    (if_pc),
    .head_instr_o (if_instr)
  );

  assign rom_pc   = pc_q;
  assign if_valid = (count != 2'd0);

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch.
module tb_ifetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [29:0] rom_pc;
  logic [15:0] rom_instruction;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [29:0] if_pc;
  logic        if_ready;

  int vectors = 0;
  int fails   = 0;
  logic [29:0] acc_q[$];
  int n_acc;

  ifetch #(
    .PC_W     (30),
    .RESET_PC (30'h0)
  ) dut (
    .sys_clk         (clk),
    .sys_rst_n       (rst_n),
    .fetch_en        (fetch_en),
    .rom_pc          (rom_pc),
    .rom_instruction (rom_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_ready        (if_ready)
  );

  // ROM model
  assign rom_instruction = rom_pc[15:0] ^ 16'hA5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // log of completed transfers
  always @(posedge clk) begin
    if (rst_n && if_valid && if_ready) acc_q.push_back(if_pc);
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [15:0] stream_instr [4];
  logic [29:0] exp_bp [3];

  initial begin
    stream_instr[0] = 16'hA5A5;
    stream_instr[1] = 16'hA5A7;
    stream_instr[2] = 16'hA5A1;
    stream_instr[3] = 16'hA5A3;
    exp_bp[0] = 30'h0;
    exp_bp[1] = 30'h2;
    exp_bp[2] = 30'h4;

    rst_n = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();

    // reset state
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_rom_pc", {2'd0, rom_pc}, 32'h0);
    chk("rst_if_pc", {2'd0, if_pc}, 32'h0);
    chk("rst_if_instr", {16'd0, if_instr}, 32'h0);
    chk("rst_state", {30'd0, dut.state_q}, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("valid_before_edge", {31'd0, if_valid}, 32'd0);
    step();

    // stream
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", {31'd0, if_valid}, 32'd1);
      chk("stream_pc", {2'd0, if_pc}, 32'(2 * i));
      chk("stream_instr", {16'd0, if_instr}, {16'd0, stream_instr[i]});
      step();
    end

    // back-pressure from reset
    rst_n = 1'b0; if_ready = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_if_pc", {2'd0, if_pc}, 32'h0);
      chk("bp_rom_pc", {2'd0, rom_pc}, 32'h4);
      chk("bp_count", {30'd0, dut.u_buf.count_q}, 32'd2);
      step();
    end
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_release_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_release_pc", {2'd0, if_pc}, {2'd0, exp_bp[i]});
      if (i < 2) step();
    end

    // redirect while full: buffer holds {4,6}
    if_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 30'h101;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_rom_pc", {2'd0, rom_pc}, 32'h100);
    step();
    chk("redir_first_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_first_pc", {2'd0, if_pc}, 32'h100);
    chk("redir_first_instr", {16'd0, if_instr}, 32'hA4A5);
    if_ready = 1'b1;
    step();
    chk("redir_second_pc", {2'd0, if_pc}, 32'h102);
    if_ready = 1'b0;
    step();
    chk("fill_pc", {2'd0, if_pc}, 32'h102);
    chk("fill_count", {30'd0, dut.u_buf.count_q}, 32'd2);

    // redirect with pop in the same cycle
    n_acc = acc_q.size();
    redirect_valid = 1'b1; redirect_pc = 30'h200; if_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("rp_acc_count", 32'(acc_q.size()), 32'(n_acc + 1));
    chk("rp_acc_pc", {2'd0, acc_q[$]}, 32'h102);
    chk("rp_valid", {31'd0, if_valid}, 32'd0);
    chk("rp_rom_pc", {2'd0, rom_pc}, 32'h200);
    step();
    chk("rp_next_valid", {31'd0, if_valid}, 32'd1);
    chk("rp_next_pc", {2'd0, if_pc}, 32'h200);

    // wrap-around
    redirect_valid = 1'b1; redirect_pc = 30'h3FFFFFFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap_valid", {31'd0, if_valid}, 32'd0);
    chk("wrap_rom_pc", {2'd0, rom_pc}, 32'h3FFFFFFE);
    step();
    chk("wrap_pc0", {2'd0, if_pc}, 32'h3FFFFFFE);
    chk("wrap_instr0", {16'd0, if_instr}, 32'h5A5B);
    step();
    chk("wrap_pc1", {2'd0, if_pc}, 32'h0);
    chk("wrap_instr1", {16'd0, if_instr}, 32'hA5A5);
    chk("wrap_rom_pc1", {2'd0, rom_pc}, 32'h2);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_rom_pc", {2'd0, rom_pc}, 32'h0);
    chk("arst_if_pc", {2'd0, if_pc}, 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    chk("arst_restart_valid", {31'd0, if_valid}, 32'd1);
    chk("arst_restart_pc", {2'd0, if_pc}, 32'h0);
    chk("arst_restart_rom", {2'd0, rom_pc}, 32'h2);

    // fetch_en low: pops continue, PC frozen
    fetch_en = 1'b0;
    step();
    chk("freeze_valid", {31'd0, if_valid}, 32'd0);
    chk("freeze_rom0", {2'd0, rom_pc}, 32'h2);
    step();
    chk("freeze_rom1", {2'd0, rom_pc}, 32'h2);
    chk("freeze_state", {30'd0, dut.state_q}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
